mem_stage_hs: RTL
=================

# mem_stage_hs

Parametrised memory pipeline stage for the RISC-V core. It sits between the EX/MEM and MEM/WB boundaries. Unlike the single-cycle MEM stage, it drives a request/acknowledge data-memory port and stalls upstream while an access is outstanding. It also aligns and sign/zero-extends load data, generates store byte enables, and aborts an access that is not acknowledged within a timeout. Non-memory instructions pass through in one cycle, as before.

## Interface
Parameters:
- XLEN, 64, data/address width; legal values 32 or 64
- CST_W, 19, control-store word width
- TIMEOUT, 16, maximum cycles in WAIT before abort; legal range 1..255

Ports (clock and reset first):
- CLK  in  1  clock; all state updates on the rising edge
- RESET_N  in  1  reset, asynchronous assert, active-low
- MEM_V  in  1  MEM latch valid
- MEM_Cst  in  CST_W  control word: [5] R_W (1 = store), [4:2] Size, [1] RES_Mux (1 = load)
- MEM_RES, MEM_Address, MEM_NPC, MEM_Target_Address  in  XLEN  ALU result / store data, effective address, next PC, branch target
- MEM_IR  in  32  instruction
- MEM_PC_MUX  in  1  PC select
- MEM_STALL  out  1  upstream must hold MEM_* inputs stable
- V_MEM_FE_BR_STALL  out  1  MEM_V and opcode[6:2] is 11000, 11001 or 11011
- MEM_DR  out  5  MEM_IR[11:7]
- DMEM_REQ  out  1  access request
- DMEM_WE  out  1  write enable
- DMEM_ADDR  out  XLEN  address with the low log2(XLEN/8) bits forced to zero
- DMEM_BE  out  XLEN/8  byte enables
- DMEM_WDATA  out  XLEN  store data, replicated across lanes
- DMEM_ACK  in  1  access complete; DMEM_RDATA valid in the same cycle
- DMEM_RDATA  in  XLEN  aligned read word
- WB_V, WB_PC_MUX, WB_ERR  out  1  WB latch valid, PC select, bus-timeout flag
- WB_Cst  out  CST_W; WB_IR  out  32
- WB_RES, WB_NPC, WB_Target_Address  out  XLEN

## Operation
- An access is MEM_V & (R_W | RES_Mux). When an instruction is both a load and a store, the store takes precedence.
- Size[1:0] encodes the access width: 00 = byte, 01 = half, 10 = word, 11 = double.
  - Size[2] = 1 selects zero-extension on loads.
  - Size 11 with XLEN = 32 is executed as a word access.
- Lane offset is Address[log2(XLEN/8)-1:0].
  - DMEM_BE is the contiguous access-width mask shifted left by the offset.
  - Load data is DMEM_RDATA shifted right by 8·offset, then extended to XLEN.
- FSM states:
  - IDLE
    - With an access pending: DMEM_REQ = 1.
      - If DMEM_ACK arrives in the same cycle, the WB latch is written and the FSM stays in IDLE.
      - Otherwise the FSM moves to WAIT and clears its cycle counter.
    - With no access pending: the WB latch is written every cycle, and WB_V = MEM_V.
  - WAIT
    - DMEM_REQ stays 1 and the request fields stay stable.
    - The counter increments each cycle.
    - On DMEM_ACK: the WB latch is written and the FSM returns to IDLE.
    - When the counter reaches TIMEOUT-1 without an ACK, the FSM goes to ABORT.
  - ABORT: one cycle. DMEM_REQ = 0. The WB latch is written with WB_ERR = 1, WB_RES = 0 and WB_V = 1; the FSM returns to IDLE.
- MEM_STALL = access pending & ~DMEM_ACK while in IDLE or WAIT; MEM_STALL = 1 in ABORT.
- When the WB latch is not being written, WB_V = 0 and the other WB_* fields hold their values.
- WB_RES takes load data when RES_Mux = 1, otherwise MEM_RES.
- Every WB write without an abort sets WB_ERR = 0.

## Timing
- Reset values: state IDLE, counter 0, all WB_* outputs 0.
- DMEM_REQ, DMEM_WE, DMEM_BE, DMEM_ADDR and DMEM_WDATA are combinational from state and MEM_*, so they are 0 while in reset.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Memory access: 1 + N cycles for an ACK N cycles after REQ.
  - Abort: TIMEOUT + 1 cycles.
- A late ACK that arrives in the ABORT cycle or in the following IDLE cycle is ignored unless a new REQ is high in that cycle.
- If RESET_N asserts mid-access, the outstanding request is dropped immediately, with no abort record written.

## Configuration
- MEM_MISALIGN_TRAP_EN
  - When defined: an access whose offset is not a multiple of its width raises no DMEM_REQ. In the next cycle the WB latch is written with WB_ERR = 1 and WB_RES = MEM_Address, with no stall.
  - When undefined: misaligned accesses are issued as-is, and any BE bits beyond the word boundary are truncated.

## Test plan
- Reset: hold RESET_N = 0 with random inputs → all WB_* = 0 and DMEM_REQ = 0. Release → first non-memory instruction appears with WB_V = 1 after 1 cycle.
- Zero-wait load: XLEN = 64, lb at address 0x1003, RDATA = 0x00000000_80000000, ACK in the same cycle → WB_RES = 0xFFFFFFFF_FFFFFF80, BE = 0x08, no stall.
- 3-cycle store: sh at 0x2006, RES = 0xABCD, ACK on the 3rd cycle → BE = 0xC0, WE = 1, MEM_STALL = 1 for 2 cycles, then WB_V = 1.
- Timeout: TIMEOUT = 4 with no ACK → REQ high for 4 cycles, then one ABORT cycle, then WB_ERR = 1, WB_RES = 0.
- Branch stall: opcode 1100011 with MEM_V = 1 → V_MEM_FE_BR_STALL = 1 and MEM_STALL = 0.
- Misalignment with MEM_MISALIGN_TRAP_EN defined: lw at 0x1002 → no REQ, next cycle WB_ERR = 1, WB_RES = 0x1002.

Source files
------------

// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - Handshaked MEM stage: dmem req/ack port, load align/extend, store byte enables, bus timeout
// Optional feature macro MEM_MISALIGN_TRAP_EN: misaligned accesses skip the bus and write an error record instead.
module mem_stage_hs #(
  parameter int XLEN    = 64,
  parameter int CST_W   = 19,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              MEM_V,
  input  logic [CST_W-1:0]  MEM_Cst,
  input  logic [XLEN-1:0]   MEM_RES,
  input  logic [XLEN-1:0]   MEM_Address,
  input  logic [XLEN-1:0]   MEM_NPC,
  input  logic [XLEN-1:0]   MEM_Target_Address,
  input  logic [31:0]       MEM_IR,
  input  logic              MEM_PC_MUX,
  output logic              MEM_STALL,
  output logic              V_MEM_FE_BR_STALL,
  output logic [4:0]        MEM_DR,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [XLEN-1:0]   DMEM_ADDR,
  output logic [XLEN/8-1:0] DMEM_BE,
  output logic [XLEN-1:0]   DMEM_WDATA,
  input  logic              DMEM_ACK,
  input  logic [XLEN-1:0]   DMEM_RDATA,
  output logic              WB_V,
  output logic              WB_PC_MUX,
  output logic              WB_ERR,
  output logic [CST_W-1:0]  WB_Cst,
  output logic [31:0]       WB_IR,
  output logic [XLEN-1:0]   WB_RES,
  output logic [XLEN-1:0]   WB_NPC,
  output logic [XLEN-1:0]   WB_Target_Address
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [7:0]       r_cnt;
  logic             r_wb_v;
  logic             r_wb_pc_mux;
  logic             r_wb_err;
  logic [CST_W-1:0] r_wb_cst;
  logic [31:0]      r_wb_ir;
  logic [XLEN-1:0]  r_wb_res;
  logic [XLEN-1:0]  r_wb_npc;
  logic [XLEN-1:0]  r_wb_target;

  logic [1:0]              w_state_nxt;
  logic [7:0]              w_cnt_nxt;
  logic                    w_is_store;
  logic                    w_is_load;
  logic                    w_access;
  logic                    w_trap;
  logic                    w_issue;
  logic                    w_zext;
  logic [1:0]              w_size;
  logic [OFF_W-1:0]        w_offset;
  logic [NB-1:0]           w_width_mask;
  logic [6:0]              w_ext_sh;
  logic [XLEN-1:0]         w_wdata;
  logic [XLEN-1:0]         w_shifted;
  logic [XLEN-1:0]         w_ext_tmp;
  logic signed [XLEN-1:0]  w_sext;
  logic [XLEN-1:0]         w_load;
  logic [XLEN-1:0]         w_wb_res_nxt;
  logic                    w_req;
  logic                    w_req_g;
  logic                    w_stall;
  logic                    w_wb_we;
  logic                    w_wb_v_nxt;
  logic                    w_wb_err_nxt;
  logic [4:0]              w_opc;

  // A store wins when both R_W and RES_Mux are set, so load data is only selected for pure loads.
  assign w_is_store = MEM_Cst[5];
  assign w_is_load  = MEM_Cst[1] & ~MEM_Cst[5];
  assign w_access   = MEM_V & (MEM_Cst[5] | MEM_Cst[1]);
  assign w_zext     = MEM_Cst[4];
  assign w_size     = (XLEN == 32 && MEM_Cst[3:2] == 2'b11) ? 2'b10 : MEM_Cst[3:2];
  assign w_offset   = MEM_Address[OFF_W-1:0];

  always_comb begin
    w_width_mask = '0;
    w_ext_sh     = 7'd0;
    unique case (w_size)
      2'b00: begin
        w_width_mask = NB'(8'h01);
        w_ext_sh     = 7'(XLEN - 8);
      end
      2'b01: begin
        w_width_mask = NB'(8'h03);
        w_ext_sh     = 7'(XLEN - 16);
      end
      2'b10: begin
        w_width_mask = NB'(8'h0F);
        w_ext_sh     = 7'(XLEN - 32);
      end
      default: begin
        w_width_mask = '1;
        w_ext_sh     = 7'd0;
      end
    endcase
  end

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      unique case (w_size)
        2'b00:   w_wdata[i*8 +: 8] = MEM_RES[7:0];
        2'b01:   w_wdata[i*8 +: 8] = MEM_RES[(i%2)*8 +: 8];
        2'b10:   w_wdata[i*8 +: 8] = MEM_RES[(i%4)*8 +: 8];
        default: w_wdata[i*8 +: 8] = MEM_RES[i*8 +: 8];
      endcase
    end
  end

  // Extension is done by parking the field at the MSB and shifting it back down.
  assign w_shifted = DMEM_RDATA >> {w_offset, 3'b000};
  assign w_ext_tmp = w_shifted << w_ext_sh;
  assign w_sext    = $signed(w_ext_tmp) >>> w_ext_sh;
  assign w_load    = w_zext ? (w_ext_tmp >> w_ext_sh) : w_sext;

`ifdef MEM_MISALIGN_TRAP_EN
  logic [OFF_W-1:0] w_align_mask;
  assign w_align_mask = (w_size == 2'b00) ? '0 :
                        (w_size == 2'b01) ? OFF_W'(1) :
                        (w_size == 2'b10) ? OFF_W'(3) : OFF_W'(7);
  assign w_trap = w_access & (|(w_offset & w_align_mask));
`else
  assign w_trap = 1'b0;
`endif

  assign w_issue = w_access & ~w_trap;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_req        = 1'b0;
    w_stall      = 1'b0;
    w_wb_we      = 1'b0;
    w_wb_v_nxt   = 1'b0;
    w_wb_err_nxt = 1'b0;
    w_wb_res_nxt = w_is_load ? w_load : MEM_RES;
    unique case (r_state)
      S_IDLE: begin
        if (w_trap) begin
          w_wb_we      = 1'b1;
          w_wb_v_nxt   = 1'b1;
          w_wb_err_nxt = 1'b1;
          w_wb_res_nxt = MEM_Address;
        end else if (w_issue) begin
          w_req = 1'b1;
          if (DMEM_ACK) begin
            w_wb_we    = 1'b1;
            w_wb_v_nxt = 1'b1;
          end else begin
            w_stall     = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = (TIMEOUT == 1) ? S_ABORT : S_WAIT;
          end
        end else begin
          w_wb_we    = 1'b1;
          w_wb_v_nxt = MEM_V;
        end
      end
      S_WAIT: begin
        w_req     = 1'b1;
        w_cnt_nxt = r_cnt + 8'd1;
        if (DMEM_ACK) begin
          w_wb_we     = 1'b1;
          w_wb_v_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_stall = 1'b1;
          if (w_cnt_nxt == CNT_LAST) begin
            w_state_nxt = S_ABORT;
          end
        end
      end
      S_ABORT: begin
        // Late ACKs are dropped here; upstream is still held for this one cycle.
        w_stall      = 1'b1;
        w_wb_we      = 1'b1;
        w_wb_v_nxt   = 1'b1;
        w_wb_err_nxt = 1'b1;
        w_wb_res_nxt = '0;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wb_v      <= 1'b0;
      r_wb_pc_mux <= 1'b0;
      r_wb_err    <= 1'b0;
      r_wb_cst    <= '0;
      r_wb_ir     <= '0;
      r_wb_res    <= '0;
      r_wb_npc    <= '0;
      r_wb_target <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wb_v  <= w_wb_we & w_wb_v_nxt;
      if (w_wb_we) begin
        r_wb_pc_mux <= MEM_PC_MUX;
        r_wb_err    <= w_wb_err_nxt;
        r_wb_cst    <= MEM_Cst;
        r_wb_ir     <= MEM_IR;
        r_wb_res    <= w_wb_res_nxt;
        r_wb_npc    <= MEM_NPC;
        r_wb_target <= MEM_Target_Address;
      end
    end
  end

  // Bus outputs are gated by reset so an in-flight request vanishes the moment reset asserts.
  assign w_req_g    = w_req & RESET_N;
  assign DMEM_REQ   = w_req_g;
  assign DMEM_WE    = w_req_g & w_is_store;
  assign DMEM_ADDR  = w_req_g ? {MEM_Address[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign DMEM_BE    = w_req_g ? (w_width_mask << w_offset) : '0;
  assign DMEM_WDATA = w_req_g ? w_wdata : '0;
  assign MEM_STALL  = w_stall & RESET_N;

  assign w_opc             = MEM_IR[6:2];
  assign V_MEM_FE_BR_STALL = MEM_V & ((w_opc == 5'b11000) | (w_opc == 5'b11001) | (w_opc == 5'b11011));
  assign MEM_DR            = MEM_IR[11:7];

  assign WB_V              = r_wb_v;
  assign WB_PC_MUX         = r_wb_pc_mux;
  assign WB_ERR            = r_wb_err;
  assign WB_Cst            = r_wb_cst;
  assign WB_IR             = r_wb_ir;
  assign WB_RES            = r_wb_res;
  assign WB_NPC            = r_wb_npc;
  assign WB_Target_Address = r_wb_target;

endmodule
